// File: rtl/uart_tx_slave_pkg.sv
// Shared types and constants for the bus-attached UART transmitter:
// FSM state encoding, register offsets and STATUS bit positions.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_slave_if.sv
// Data-bus slave slot used by the UART transmitter; the core drives the
// address/write side, the slave returns combinational read data.
interface uart_tx_slave_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] busaddr;
  logic [WIDTH-1:0] buswdata;
  logic             buswrite;
  logic [WIDTH-1:0] busrdata;

  modport master (output busaddr, output buswdata, output buswrite, input busrdata);
  modport slave  (input busaddr, input buswdata, input buswrite, output busrdata);
endinterface

// File: rtl/uart_tx_slave_txfifo.sv
// Synchronous TX byte FIFO with combinational head; a push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module txfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block ordered against reads of the old values in other blocks.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by
  // count_q, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_slave.sv
// Bus-attached 8N1 UART transmitter with TX FIFO, STATUS register and irq.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_slave
  import uart_tx_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CLKDIV    = 868,
  parameter int FIFODEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_slave_if.slave        bus,
  output logic                  datao,
  output logic                  irq
);

  localparam int CW = $clog2(FIFODEPTH) + 1;
  localparam int DW = $clog2(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  logic [1:0]    reg_sel;
  logic          push, pop, drop, ovf_clr;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          div_expire;
  logic [WIDTH-1:0] status;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          datao_q, datao_d;
  logic          ovf_q, ovf_d;

  assign reg_sel = bus.busaddr[3:2];
  assign push    = bus.buswrite && (reg_sel == REG_TXDATA);
  assign ovf_clr = bus.buswrite && (reg_sel == REG_STATUS) && bus.buswdata[ST_OVF];
  assign drop    = push && fifo_full && !pop;

  txfifo #(
    .WIDTH (8),
    .DEPTH (FIFODEPTH)
  ) u_txfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.buswdata[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign div_expire = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    state_d = state_q;
    div_d   = div_expire ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    datao_d = datao_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          par_d   = ^fifo_head;
          datao_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_expire) begin
          bit_d   = 3'd0;
          datao_d = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (div_expire) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            datao_d = par_q;
            state_d = S_PARITY;
`else
            datao_d = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            datao_d = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (div_expire) begin
          datao_d = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (div_expire) begin
          // Chain straight into the next start bit so frames are gapless.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            par_d   = ^fifo_head;
            datao_d = 1'b0;
            state_d = S_START;
          end else begin
            datao_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        div_d   = '0;
        datao_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      datao_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      datao_q <= datao_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                        = '0;
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_BUSY]               = (state_q != S_IDLE);
    status[ST_OVF]                = ovf_q;
    status[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    bus.busrdata = (reg_sel == REG_STATUS) ? status : '0;
  end

  assign datao = datao_q;
  assign irq   = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_slave.sv
// Self-checking bench for uart_tx_slave: a line decoder checks every frame
// against a queue of expected bytes, plus directed STATUS/timing checks.
module tb_uart_tx_slave;

  localparam int WIDTH  = 32;
  localparam int CLKDIV = 4;
  localparam int DEPTH  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CLKDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic datao, irq;

  uart_tx_slave_if #(.WIDTH(WIDTH)) bus_if ();

  uart_tx_slave #(
    .WIDTH     (WIDTH),
    .CLKDIV    (CLKDIV),
    .FIFODEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .datao (datao),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];
  int frames_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples each bit at mid-period once a start edge appears.
  logic         mon_active = 1'b0;
  int           mon_cnt = 0;
  logic [FB-1:0] mon_bits;
  logic [7:0]   mon_byte, mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && datao === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
      if (mon_active) begin
        if (mon_cnt % CLKDIV == CLKDIV / 2) mon_bits[mon_cnt / CLKDIV] = datao;
        if (mon_cnt == FRAME - 1) begin
          mon_byte = mon_bits[8:1];
          check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
          check("stop_bit", {31'd0, mon_bits[FB-1]}, 32'd1);
          check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("frame_data", {24'd0, mon_byte}, {24'd0, mon_exp});
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'd0, mon_bits[9]}, {31'd0, ^mon_exp});
`endif
          end
          frames_seen++;
          mon_active = 1'b0;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.busaddr  = addr;
    bus_if.buswdata = data;
    bus_if.buswrite = 1'b1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus_if.buswrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.buswrite = 1'b0;
    bus_if.busaddr  = addr;
    #1;
    data = bus_if.busrdata;
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit busy);
    return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(busy) << 2) |
           (32'(cnt == 0) << 1) | 32'(cnt == DEPTH);
  endfunction

  // Counts cycles during which STATUS.busy reads 1, until it drops again.
  task automatic measure_busy(output int cyc);
    logic [31:0] s;
    cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      bus_read(32'h4, s);
      if (s[2]) cyc++;
      else if (cyc > 0) break;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bus_idle();
    while (!(irq === 1'b1 && !mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'd0, n < budget}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic send_one(input logic [7:0] b);
    int cyc;
    bus_write(32'h0, {24'hABCDEF, b});
    exp_q.push_back(b);
    measure_busy(cyc);
    check("frame_cycles", cyc, FRAME);
    check("irq_after_frame", {31'd0, irq}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          cyc, n, gap, mcnt, lows, frames_before;
    bit          movf;

    bus_if.busaddr  = '0;
    bus_if.buswdata = '0;
    bus_if.buswrite = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_datao", {31'd0, datao}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    rst = 1'b0;
    bus_read(32'h4, rd);
    check("reset_status", rd, 32'h0000_0002);

    // Unmapped / write-only registers; higher address bits ignored.
    bus_read(32'h0, rd);  check("txdata_reads_zero", rd, 32'h0);
    bus_read(32'h8, rd);  check("reg2_reads_zero", rd, 32'h0);
    bus_read(32'hC, rd);  check("reg3_reads_zero", rd, 32'h0);
    bus_read(32'hF4, rd); check("status_alias", rd, 32'h0000_0002);
    bus_write(32'h8, 32'hAA);
    bus_write(32'hC, 32'h55);
    bus_read(32'h4, rd);  check("reserved_write_ignored", rd, 32'h0000_0002);

    // Single frames: 0x55 and the parity cases.
    send_one(8'h55);
    send_one(8'h07);
    send_one(8'h03);

    // Back-to-back frames, no idle gap.
    bus_write(32'h0, 32'hA3);
    bus_write(32'h0, 32'h0F);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    measure_busy(cyc);
    check("back_to_back_cycles", cyc, 2 * FRAME);
    wait_idle(200);

    // Overflow: serializer busy, then 17 consecutive pushes.
    bus_write(32'h0, 32'h11);
    exp_q.push_back(8'h11);
    bus_idle();
    bus_idle();
    mcnt = 0;
    movf = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      bus_write(32'h0, {24'd0, b});
      if (mcnt < DEPTH) begin
        exp_q.push_back(b);
        mcnt++;
      end else begin
        movf = 1'b1;
      end
    end
    bus_read(32'h4, rd);
    check("ovf_status", rd, status_word(mcnt, movf, 1'b1));
    bus_read(32'h0, rd);
    check("txdata_reads_zero_full", rd, 32'h0);
    bus_write(32'h4, 32'h0);
    bus_read(32'h4, rd);
    check("ovf_kept_without_bit3", rd, status_word(mcnt, movf, 1'b1));
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, rd);
    check("ovf_cleared", rd, status_word(mcnt, 1'b0, 1'b1));
    wait_idle((DEPTH + 2) * FRAME + 100);

    // Randomized bursts with random gaps, never enough to overflow.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bus_write(32'h0, {24'($urandom), b});
        exp_q.push_back(b);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) bus_idle();
      end
      wait_idle(10 * FRAME + 100);
      bus_read(32'h4, rd);
      check("status_after_burst", rd, 32'h0000_0002);
    end

    // Reset mid-frame discards the frame and the queued byte.
    frames_before = frames_seen;
    bus_write(32'h0, 32'h00);
    bus_write(32'h0, 32'h5A);
    bus_idle();
    n = 0;
    while (datao !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_seen_before_reset", {31'd0, n < 50}, 32'd1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_datao", {31'd0, datao}, 32'd1);
    check("abort_irq", {31'd0, irq}, 32'd1);
    bus_read(32'h4, rd);
    check("abort_status", rd, 32'h0000_0002);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (datao !== 1'b1) lows++;
    end
    check("no_start_after_reset", lows, 32'd0);
    check("no_frame_after_reset", frames_seen - frames_before, 32'd0);
    bus_read(32'h4, rd);
    check("status_after_abort", rd, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_slave.md
Name: uart_tx_slave

Overview:
- Bus-attached UART transmitter. It is a slave on the data bus, occupying one slave slot alongside ram and dualram.
- The core writes encoded JPEG bytes into a small FIFO over the bus. The block serializes them 8N1, LSB first, on a single output line.
- It is the outbound counterpart to the receive path that fills dualram, and it gives firmware a polled byte stream out.

Parameters:
- WIDTH, 32, bus data/address width.
- CLKDIV, 868, clk cycles per serial bit (>=2).
- FIFODEPTH, 16, TX FIFO entries, power of two, >=2.

Ports:
- clk  in  1  block clock (the core clock domain).
- rst  in  1  reset, synchronous, active-high.
- busaddr  in  WIDTH  slave address from bus.
- buswdata  in  WIDTH  write data from bus.
- buswrite  in  1  write strobe; one access per cycle while high.
- busrdata  out  WIDTH  read data, combinational from busaddr and current state.
- datao  out  1  serial line, idles high.
- irq  out  1  high while FIFO empty and serializer idle (transmit done).

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Register decode uses busaddr[3:2]; higher bits are ignored.
  - 0 TXDATA (write-only; reads return 0).
  - 1 STATUS.
  - 2 and 3 read 0 and ignore writes.
- TXDATA write pushes buswdata[7:0]; upper bits are ignored.
- Push acceptance:
  - Accepted if FIFO not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky ovf is set.
- STATUS read layout: bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 ovf, bits[15:8] count (zero-extended), others 0.
- STATUS write with buswdata[3]=1 clears ovf. If a dropped push occurs the same cycle, set wins.
- Reset values at the next clk edge with rst high:
  - datao=1, FIFO empty, count=0, ovf=0, FSM=IDLE, bit counter=0, divider=0, irq=1.
  - busrdata reads STATUS as 0x00000002.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, clear the divider, and go to START. datao is registered and becomes 0 at that edge.
  - START: hold datao=0 for CLKDIV cycles, then go to DATA with datao=shift[0].
  - DATA: each bit lasts CLKDIV cycles; shift right on expiry. After the 8th bit go to STOP with datao=1.
  - STOP: hold 1 for CLKDIV cycles. On expiry:
    - if FIFO non-empty, pop and go directly to START (no idle gap between frames);
    - else go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKDIV cycles.
  - Push at edge N into an idle block: pop at edge N+1, datao low from N+1.
- Divider counts 0..CLKDIV-1 and wraps; expiry is the cycle at count CLKDIV-1.
- FIFO pointers wrap modulo FIFODEPTH. count is $clog2(FIFODEPTH)+1 bits and ranges 0..FIFODEPTH.
- Reset mid-frame aborts the frame: datao returns to 1 at that edge, and the FIFO contents are discarded.
- busrdata reflects state before the current edge; a read and a write in the same cycle return the pre-write status.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKDIV cycles.
  - datao = even parity (XOR of the 8 data bits).
  - Frame is 11*CLKDIV cycles.
- Undefined: no PARITY state; 8N1 as above.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - register offset localparams REG_TXDATA=2'd0, REG_STATUS=2'd1;
  - STATUS bit-position constants.
- One sub-module: txfifo.
  - Synchronous FIFO parameterized by width 8 and FIFODEPTH.
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, count.
  - Same clk/rst conventions.

Test Plan (CLKDIV=4, FIFODEPTH=16):
- Reset then read STATUS -> 0x00000002; datao=1; irq=1.
- Write TXDATA=0x55 -> datao = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles), then busy=0 and irq=1.
- Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, no high gap between stop and second start, 80 cycles total.
- With the serializer busy, write 17 bytes -> count=16, full=1, ovf=1; write STATUS 0x8 -> ovf=0; all 16 bytes emerge in order.
- Assert rst at cycle 13 of a frame of 0x00 -> datao=1 next edge, STATUS=0x00000002, no further start bits.
- UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1 and frame of 44 cycles; write 0x03 -> parity bit=0.
